alu_share_ctrl: RTL

//  Sequences one shared combinational ALU between two requesters (e.g. execute stage, address-gen unit).

---
 rtl/alu_share_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: round-robin grant, launch, capture, response.
// Optional macro ALU_FLAG_REG_EN enables the architectural NZCV register and honours req_setf.
module alu_share_ctrl #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic [1:0][3:0]       req_op,
  input  logic [1:0]            req_setf,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [3:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic [3:0]            alu_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags,
  output logic                  rsp_err,
  output logic [3:0]            nzcv
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_id;
  logic             grant_any;
  logic             accept;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [3:0]       op_p0;
  logic             id_p0;

  function automatic logic op_legal(input logic [3:0] op);
    return !op[3] || (op == 4'b1011) || (op == 4'b1100);
  endfunction

  function automatic logic op_has_v(input logic [3:0] op);
    return (op == 4'b0011) || (op == 4'b1011);
  endfunction

  // The ALU leaves V undefined for ops that do not compute overflow.
  function automatic logic [3:0] sanitise(input logic [3:0] flags, input logic [3:0] op);
    return {flags[3:1], op_has_v(op) ? flags[0] : 1'b0};
  endfunction

  always_comb begin
    grant_any = |req_valid;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_nxt           = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) last_grant <= grant_id;
    end
  end

  // Launch stage: operands held here also drive the ALU, so it stays quiet between ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= '0;
      id_p0 <= 1'b0;
    end else if (accept) begin
      a_p0  <= req_a[grant_id];
      b_p0  <= req_b[grant_id];
      op_p0 <= req_op[grant_id];
      id_p0 <= grant_id;
    end
  end

  assign alu_a    = a_p0;
  assign alu_b    = b_p0;
  assign alu_ctrl = op_p0;

  // Capture stage: ALU result sampled at the end of the single EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id     <= id_p0;
      rsp_err    <= !op_legal(op_p0);
      rsp_result <= op_legal(op_p0) ? alu_result : '0;
      rsp_flags  <= op_legal(op_p0) ? sanitise(alu_flags, op_p0) : 4'b0000;
    end
  end

  assign rsp_valid = (state == RESP);

`ifdef ALU_FLAG_REG_EN
  logic setf_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       setf_p0 <= 1'b0;
    else if (accept) setf_p0 <= req_setf[grant_id];
  end

  // V is only architecturally meaningful for add/sub; otherwise it is preserved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nzcv <= FLAG_RST;
    end else if ((state == EXEC) && setf_p0 && op_legal(op_p0)) begin
      nzcv <= {alu_flags[3:1], op_has_v(op_p0) ? alu_flags[0] : nzcv[0]};
    end
  end
`else
  logic unused_setf;

  assign unused_setf = ^req_setf;
  assign nzcv        = FLAG_RST;
`endif

endmodule
